bram_fifo: RTL
==============

Name: bram_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO controller built around one bram_2psync instance.
- Memory port B is the write port; port A is the read port.
- The block owns the write/read pointers, occupancy, status flags and error flags, and sequences the memory so that the head word is always visible on rd_data.
- Sits between a streaming producer and consumer in the same clock domain; it is the standard buffer used by the UART/DMA-style paths.

Parameters:
- DATA_W, 8, word width; passed to bram_2psync.
- ADDR_W, 12, address width; depth = 2**ADDR_W; passed to bram_2psync.
- AF_MARGIN, 4, almost_full asserts when count >= 2**ADDR_W - AF_MARGIN.
- AE_MARGIN, 4, almost_empty asserts when count <= AE_MARGIN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- flush  in  1  synchronous clear of FIFO state.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- full  out  1  no free entry.
- almost_full  out  1  see AF_MARGIN.
- rd_en  in  1  pop request; acknowledges the current rd_data.
- rd_data  out  DATA_W  head word; valid while empty=0.
- empty  out  1  no stored entry.
- almost_empty  out  1  see AE_MARGIN.
- count  out  ADDR_W+1  occupancy, 0..2**ADDR_W.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Memory contents are not cleared. rd_data is don't-care while empty=1.
- Output values after reset: empty=1, full=0, almost_empty=1, almost_full=0.
- Accepted write (wr_acc) = wr_en & ~full. Accepted read (rd_acc) = rd_en & ~empty. Both are evaluated on registered flags.
- Write connection: b_we=wr_acc, b_addr=wr_ptr, b_write=wr_data. On wr_acc, wr_ptr increments, wrapping modulo 2**ADDR_W.
- Read connection: a_addr is driven combinationally with rd_ptr_next.
  - rd_ptr_next = 0 under reset or flush; otherwise rd_ptr + rd_acc.
  - Because the memory registers a_addr and reads combinationally, rd_data = mem[rd_ptr] at all times. This gives FWFT with no output register and zero pop latency.
- A word written at edge t is visible on rd_data and empty=0 after edge t. This holds because the write and the address register update on the same edge and the read is combinational.
- Count update: count += wr_acc - rd_acc.
  - Simultaneous wr_acc and rd_acc leaves count unchanged; both pointers advance.
- Flags: full = (count == 2**ADDR_W); empty = (count == 0). All flags decode combinationally from the count register only, never from inputs.
- Full: writes are rejected even if rd_en is asserted the same cycle. A rejected write sets overflow; the pop still happens.
- Empty: reads are rejected even if wr_en is asserted the same cycle. A rejected read sets underflow; the write still happens.
- Flush=1 at an edge:
  - Pointers and count go to 0.
  - wr_en/rd_en in that cycle are ignored and flag no errors.
  - overflow/underflow are cleared.
  - rst_n has priority over flush.
- Reset or flush mid-stream discards all stored words. The first subsequent write lands at address 0.
- b_read is left unconnected.

Decomposition:
- Shared package holds:
  - fifo_depth(ADDR_W) = 2**ADDR_W.
  - The count-width constant (ADDR_W+1).
- One sub-module: bram_2psync, instantiated with the same DATA_W/ADDR_W. All control (pointers, counter, flags, errors) lives in bram_fifo itself.

Test Plan (ADDR_W=3, depth 8, AF_MARGIN=2, AE_MARGIN=1):
- Release reset, write 0xA5 for one cycle -> after that edge empty=0, rd_data=0xA5, count=1, almost_empty=1; pop -> empty=1, count=0.
- Write 0x10..0x17 back-to-back -> almost_full at count=6, full at count=8; a 9th write (0x18) is rejected -> overflow=1, count stays 8; pop 8 -> rd_data 0x10..0x17 in order.
- Pop while empty with simultaneous wr_en (0x33) -> underflow=1, count=1, rd_data=0x33.
- At count=3, hold wr_en and rd_en for 20 cycles writing an incrementing value -> count stays 3, pointers wrap twice, every popped word matches the model.
- At full, assert rd_en and wr_en together -> pop accepted, write rejected, overflow=1, count=7.
- Mid-stream flush with wr_en=1, then rst_n=0 at count=5 -> count=0, empty=1, errors cleared, next write 0x42 appears on rd_data after one edge.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared sizing helpers for the BRAM-backed FWFT FIFO.
package bram_fifo_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO can be represented.
  localparam int COUNT_EXTRA_BITS = 1;

  function automatic int count_width(input int addr_w);
    return addr_w + COUNT_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/bram_2psync.sv
// Two-port synchronous RAM: addresses are registered and reads are combinational from the registered address.
// Port B writes; both ports can read.
module bram_2psync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_read,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_write,
  output logic [DATA_W-1:0] b_read
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] a_addr_reg;
  logic [ADDR_W-1:0] b_addr_reg;

  always_ff @(posedge clk) begin
    if (b_we) begin
      mem[b_addr] <= b_write;
    end
    a_addr_reg <= a_addr;
    b_addr_reg <= b_addr;
  end

  assign a_read = mem[a_addr_reg];
  assign b_read = mem[b_addr_reg];

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO controller around one bram_2psync.
// The read address is presented one cycle early so rd_data always shows the head word.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [count_width(ADDR_W)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CNT_W = count_width(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(fifo_depth(ADDR_W));
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(fifo_depth(ADDR_W) - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(AE_MARGIN);

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              wr_acc;
  logic              rd_acc;

  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_LEVEL);
  assign almost_empty = (count_reg <= AE_LEVEL);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Read address must already point at the new head when the edge registers it.
  always_comb begin
    rd_ptr_next = rd_ptr_reg + ADDR_W'(rd_acc);
    if (!rst_n || flush) begin
      rd_ptr_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    rd_ptr_reg <= rd_ptr_next;
    if (!rst_n || flush) begin
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  bram_2psync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .a_addr (rd_ptr_next),
    .a_read (rd_data),
    .b_we   (wr_acc),
    .b_addr (wr_ptr_reg),
    .b_write(wr_data),
    .b_read ()
  );

endmodule
